// File: rtl/iq_free_list_pkg.sv
// Issue-queue shared definitions.
// Holds the queue geometry used by the free list, the select tree and addr_cmp,
// plus the slot-index type that all of them pass around.
package iq_free_list_pkg;

    localparam int IQ_ENTRY_NUM = 32;
    localparam int IQ_ADDR_W    = 5;

    typedef logic [IQ_ADDR_W-1:0] slot_idx_t;

endpackage

// File: rtl/ptr_ring.sv
// Wrapping ring pointer.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, pointer -> 0
//   clr  - synchronous clear (flush), pointer -> 0
//   inc  - advance the pointer by one, wrapping at 2**W-1 -> 0
//   ptr  - current pointer value
module ptr_ring #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Power-of-two ring: natural overflow of the W-bit add is the wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/iq_free_list.sv
// Issue-queue slot allocator.
// A circular FIFO of free slot indices plus a per-slot busy bitmap. Dispatch
// pops indices from the head; slots granted by the select tree are pushed
// back at the tail. Frees of slots that are not busy are rejected and flagged.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - restores the reset state, overrides alloc/free
//   alloc_req       - dispatch wants one slot this cycle
//   alloc_ok        - at least one slot is free; alloc_addr is valid
//   alloc_addr      - index handed out when alloc_req & alloc_ok
//   free_valid      - select-tree grant (ready01)
//   free_addr       - granted slot (addr01)
//   free_cnt        - number of free slots, 0..ENTRY_NUM
//   busy            - per-slot allocated bitmap
//   err             - sticky illegal-free flag, cleared by reset or flush
module iq_free_list
    import iq_free_list_pkg::*;
#(
    parameter int ENTRY_NUM = IQ_ENTRY_NUM,
    parameter int ADDR_W    = IQ_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 alloc_req,
    output logic                 alloc_ok,
    output logic [ADDR_W-1:0]    alloc_addr,
    input  logic                 free_valid,
    input  logic [ADDR_W-1:0]    free_addr,
    output logic [ADDR_W:0]      free_cnt,
    output logic [ENTRY_NUM-1:0] busy,
    output logic                 err
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] fifo [ENTRY_NUM];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic              alloc_fire;
    logic              legal_free;
    logic              illegal_free;

    assign alloc_ok     = (free_cnt != '0);
    assign alloc_addr   = fifo[head];
    assign alloc_fire   = alloc_req & alloc_ok;
    assign legal_free   = free_valid & busy[free_addr];
    assign illegal_free = free_valid & ~busy[free_addr];

    ptr_ring #(.W(ADDR_W)) u_head (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (alloc_fire),
        .ptr (head)
    );

    ptr_ring #(.W(ADDR_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (legal_free),
        .ptr (tail)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                fifo[i] <= ADDR_W'(i);
            end
            free_cnt <= CNT_W'(ENTRY_NUM);
            busy     <= '0;
            err      <= 1'b0;
        end else begin
            if (legal_free) begin
                fifo[tail] <= free_addr;
            end
            // A legal free targets a busy slot and alloc only hands out
            // non-busy slots, so the two bitmap writes never collide.
            if (alloc_fire) begin
                busy[alloc_addr] <= 1'b1;
            end
            if (legal_free) begin
                busy[free_addr] <= 1'b0;
            end
            free_cnt <= free_cnt + CNT_W'(legal_free) - CNT_W'(alloc_fire);
            if (illegal_free) begin
                err <= 1'b1;
            end
        end
    end

endmodule
